// File: rtl/ppi_kbd_ctrl.sv
// rtl/ppi_kbd_ctrl.sv - keyboard deserialiser, scan-code FIFO and PPI port-A/IRQ1 handshake
// Optional: define KBD_PARITY_CHECK_EN to reject frames with bad odd parity.
module ppi_kbd_ctrl #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kbd_clk,
   input  logic       kbd_data,
   input  logic       pb_clear,
   input  logic       pb_kclk_en,
   output logic [7:0] pa_data,
   output logic       irq1,
   output logic       kbd_clk_oe,
   output logic       overflow,
   output logic       frame_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] RX_IDLE = 2'd0;
   localparam logic [1:0] RX_DATA = 2'd1;
   localparam logic [1:0] RX_PAR  = 2'd2;
   localparam logic [1:0] RX_STOP = 2'd3;

   localparam logic [1:0] P_WAIT  = 2'd0;
   localparam logic [1:0] P_HOLD  = 2'd1;
   localparam logic [1:0] P_CLEAR = 2'd2;

   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic                   kclk_prev;
   logic                   fall, kdat;

   logic [1:0]    rx_state;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic [TW-1:0] tcnt;
   logic          par_ok, push_req, timeout_hit;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, empty, do_push, do_pop;

   logic [1:0]    p_state;
   logic          pb_clear_q, clr_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= '1;
         dat_sync  <= '1;
         kclk_prev <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd_clk};
         dat_sync  <= {dat_sync[SYNC_STAGES-2:0], kbd_data};
         kclk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall = kclk_prev & ~clk_sync[SYNC_STAGES-1];
   assign kdat = dat_sync[SYNC_STAGES-1];

`ifdef KBD_PARITY_CHECK_EN
   logic par_bit;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_bit <= 1'b0;
      else if (rx_state == RX_PAR && fall)
         par_bit <= kdat;
   end
   assign par_ok = ^{shreg, par_bit};
`else
   assign par_ok = 1'b1;
`endif

   assign timeout_hit = (rx_state != RX_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
   assign push_req    = pb_kclk_en && (rx_state == RX_STOP) && fall && kdat && par_ok;

   // Inhibit wins over everything and discards silently; timeout aborts loudly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state  <= RX_IDLE;
         bitcnt    <= 3'd0;
         shreg     <= 8'h00;
         tcnt      <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (!pb_kclk_en) begin
            rx_state <= RX_IDLE;
            tcnt     <= '0;
         end else if (timeout_hit) begin
            rx_state  <= RX_IDLE;
            tcnt      <= '0;
            frame_err <= 1'b1;
         end else begin
            if (fall || rx_state == RX_IDLE)
               tcnt <= '0;
            else
               tcnt <= tcnt + 1'b1;
            if (fall) begin
               case (rx_state)
                  RX_IDLE: if (!kdat) begin
                     rx_state <= RX_DATA;
                     bitcnt   <= 3'd0;
                  end
                  RX_DATA: begin
                     shreg  <= {kdat, shreg[7:1]};
                     bitcnt <= bitcnt + 3'd1;
                     if (bitcnt == 3'd7)
                        rx_state <= RX_PAR;
                  end
                  RX_PAR:  rx_state <= RX_STOP;
                  default: begin
                     rx_state <= RX_IDLE;
                     if (!(kdat && par_ok))
                        frame_err <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   assign full     = (count == CW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push_req & ~full;
   assign do_pop   = (p_state == P_WAIT) && !empty && !pb_clear;
   assign clr_rise = pb_clear & ~pb_clear_q;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         kbd_clk_oe <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
         // A drop in the same cycle as an ack still leaves overflow set.
         if (push_req && full)
            overflow <= 1'b1;
         else if (clr_rise)
            overflow <= 1'b0;
         kbd_clk_oe <= ~pb_kclk_en | full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state    <= P_WAIT;
         pb_clear_q <= 1'b0;
         pa_data    <= 8'h00;
         irq1       <= 1'b0;
      end else begin
         pb_clear_q <= pb_clear;
         case (p_state)
            P_WAIT: if (do_pop) begin
               pa_data <= mem[rd_ptr];
               irq1    <= 1'b1;
               p_state <= P_HOLD;
            end
            P_HOLD: if (clr_rise) begin
               pa_data <= 8'h00;
               irq1    <= 1'b0;
               p_state <= P_CLEAR;
            end
            default: if (!pb_clear)
               p_state <= P_WAIT;
         endcase
      end
   end

endmodule

// File: doc/ppi_kbd_ctrl.md
Name: ppi_kbd_ctrl

Overview:
Keyboard-side controller for the system PPI (8255).
- Deserialises the keyboard's clock/data frames and buffers scan codes in a small FIFO.
- Presents one code at a time on the PPI port-A input and raises IRQ1.
- Sequences the handshake from PPI port B: PB7 is the clear/acknowledge, PB6 is the keyboard-clock enable.
- Sits between the keyboard connector and the intel8255 instance, in the clk domain.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 50000, clk cycles without a kbd_clk falling edge before an in-progress frame is aborted
SYNC_STAGES, 2, synchroniser flops on kbd_clk/kbd_data (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
kbd_clk  input  1  keyboard clock, asynchronous
kbd_data  input  1  keyboard data, asynchronous
pb_clear  input  1  PPI PB7; rising edge acknowledges the presented code
pb_kclk_en  input  1  PPI PB6; 0 = inhibit the keyboard
pa_data  output  8  scan code to PPI port A
irq1  output  1  keyboard interrupt request, level
kbd_clk_oe  output  1  1 = pull kbd_clk low (inhibit/flow control)
overflow  output  1  sticky; a code was dropped
frame_err  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset (async, rst_n=0):
  - pa_data=0x00, irq1=0, kbd_clk_oe=0, overflow=0, frame_err=0.
  - FIFO empty, both FSMs in their first state.
- Sync/edge detect: kbd_clk and kbd_data pass through SYNC_STAGES flops. A falling edge is synced-clk 1 in the previous cycle and 0 now. All sampling happens on that cycle.
- Receive FSM (RX_IDLE, RX_DATA, RX_PAR, RX_STOP):
  - RX_IDLE: on a falling edge with data=0 (start bit), go to RX_DATA with bitcnt=0. data=1 is ignored.
  - RX_DATA: shift data in LSB first. After the 8th bit go to RX_PAR.
  - RX_PAR: latch the parity bit and go to RX_STOP.
  - RX_STOP: sample the stop bit, then return to RX_IDLE.
    - stop=1 and parity valid: push the byte.
    - otherwise: frame_err pulses and the byte is discarded.
  - Timeout counter clears on every falling edge. If in any state other than RX_IDLE for TIMEOUT_CYC cycles: go to RX_IDLE, discard, pulse frame_err.
  - pb_kclk_en=0: RX goes to RX_IDLE immediately and any partial frame is silently discarded (no frame_err).
- Flow control: kbd_clk_oe = ~pb_kclk_en | fifo_full, registered.
  - If the FIFO fills mid-frame, that frame is still received.
  - A push while full drops the byte and sets overflow.
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full when count==FIFO_DEPTH.
- Present FSM (P_WAIT, P_HOLD, P_CLEAR):
  - P_WAIT: if the FIFO is non-empty, the next clk does pa_data<=head, pop, irq1<=1, then goes to P_HOLD. Latency from the stop-bit edge to irq1 rising is 2 clk when the FIFO was empty.
  - P_HOLD: hold pa_data and irq1. On a pb_clear rising edge (compared with pb_clear registered in clk): irq1<=0, pa_data<=0x00, go to P_CLEAR.
  - P_CLEAR: wait for pb_clear==0, then go to P_WAIT. A new code is never presented while pb_clear is high.
  - A pb_clear rising edge in any state clears overflow.
- pb_kclk_en has no effect on the present FSM; buffered codes still drain while the keyboard is inhibited.

Optional Feature:
KBD_PARITY_CHECK_EN
- Defined: parity valid only if data plus parity bit has an odd number of ones; otherwise the frame is discarded with frame_err.
- Undefined: the parity bit is sampled but ignored; frames are accepted on stop bit alone.

Test Plan:
- Reset with inputs idle -> pa_data=0x00, irq1=0, kbd_clk_oe=0, overflow=0; kbd_clk held 1 for 3*TIMEOUT_CYC -> no change.
- Frame 0x1C (bits 0,00111000,P=0,1) -> irq1=1 and pa_data=0x1C 2 clk after the stop edge; pb_clear 0->1 -> irq1=0, pa_data=0x00; pb_clear->0 -> remains P_WAIT.
- Frames 0x1C, 0x5A (P=1), 0xF0 (P=1) back-to-back before any ack -> presented in order, each only after pb_clear falls.
- FIFO_DEPTH+2 frames with no ack:
  - kbd_clk_oe=1 once full; the extra frame forced in -> overflow=1.
  - first FIFO_DEPTH codes intact; pb_clear rise clears overflow.
- Frame 0x5A with P=0 -> frame_err pulse, no irq1 (KBD_PARITY_CHECK_EN defined); irq1 with 0x5A (undefined). Stop bit 0 -> frame_err either way.
- 4 data bits then silence -> frame_err after TIMEOUT_CYC, next good 0x1C received.
- pb_kclk_en=0 mid-frame -> kbd_clk_oe=1 next cycle, partial frame dropped without frame_err.
